// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the I/O port sequencer.
//   io_state_e   : handshake FSM state encoding (IDLE/REQ/RELEASE/DONE)
//   OPC_PIN/POUT : opcodes of the I/O instructions decoded by main control
//   TO_ERR_DATA  : value returned to write-back when a PIN transfer times out
package io_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StRelease = 2'd2,
    StDone    = 2'd3
  } io_state_e;

  localparam logic [5:0]  OPC_PIN     = 6'h1f;
  localparam logic [5:0]  OPC_POUT    = 6'h1e;
  localparam logic [31:0] TO_ERR_DATA = 32'h0;

  function automatic logic is_io_opcode(input logic [5:0] opcode);
    return (opcode == OPC_PIN) || (opcode == OPC_POUT);
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Cycle counter bounding how long the sequencer waits on any single ack edge.
//   clk, rst : core clock, asynchronous active-high reset
//   clr      : synchronous clear (state entry)
//   en       : count this cycle (waiting on ack)
//   expired  : this is the TIMEOUT-th waiting cycle since the last clear
module io_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // The count holds cycles already elapsed, so the current cycle is number cnt_q+1.
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Must not depend on clr: clr is derived from the next state, which depends on expired.
  assign expired = en && (cnt_q == LastCnt);

endmodule

// File: rtl/io_port_sequencer.sv
// Sequences PIN/POUT instructions onto an external bus with a 4-phase req/ack handshake,
// stalling the pipeline until the transfer completes.
//   clk, rst          : core clock, asynchronous active-high reset
//   pin_en, pout_en   : I/O instruction in EX (PIN has priority)
//   io_addr, wr_data  : port address and POUT data from EX
//   stall             : freeze PC / IF-ID / ID-EX
//   rd_data, rd_valid : PIN result and its one-cycle commit strobe
//   io_req, io_we, io_addr_o, io_wdata, io_ack, io_rdata : peripheral handshake bus
//   timeout_err, clr_err : sticky timeout flag and its synchronous clear
module io_port_sequencer
  import io_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_en,
  input  logic              pout_en,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              io_req,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr_o,
  output logic [DATA_W-1:0] io_wdata,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              timeout_err,
  input  logic              clr_err
);

  io_state_e state_q, state_d;

  logic              start;
  logic              abort;
  logic              to_expired;
  logic              to_en;
  logic              to_clr;
  logic              io_req_q, io_req_d;
  logic              io_we_q, io_we_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              timeout_err_q, timeout_err_d;

  assign start  = pin_en | pout_en;
  assign to_en  = (state_q == StReq) || (state_q == StRelease);
  assign to_clr = (state_d != state_q);

  io_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; an ack edge arriving in the expiry cycle still completes normally.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReq;
      end
      StReq: begin
        if (io_ack) begin
          state_d = StRelease;
        end else if (to_expired) begin
          state_d = StDone;
          abort   = 1'b1;
        end
      end
      StRelease: begin
        if (!io_ack) begin
          state_d = StDone;
        end else if (to_expired) begin
          state_d = StDone;
          abort   = 1'b1;
        end
      end
      StDone: begin
        // Enables still reflect the instruction that is retiring now.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: stall is combinational so the decode cycle itself is frozen.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:    stall = start;
      StReq:     stall = 1'b1;
      StRelease: stall = 1'b1;
      StDone:    stall = 1'b0;
      default:   stall = 1'b0;
    endcase
  end

  // Registered bus and result next-state, so every external output is glitch-free.
  always_comb begin
    io_addr_d     = io_addr_q;
    io_wdata_d    = io_wdata_q;
    io_we_d       = io_we_q;
    rd_data_d     = rd_data_q;
    timeout_err_d = timeout_err_q;

    if ((state_q == StIdle) && start) begin
      io_addr_d  = io_addr;
      io_wdata_d = wr_data;
      io_we_d    = !pin_en;
    end

    if ((state_q == StReq) && io_ack && !io_we_q) begin
      rd_data_d = io_rdata;
    end else if (abort && !io_we_q) begin
      rd_data_d = DATA_W'(TO_ERR_DATA);
    end

    if (abort) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end

    io_req_d   = (state_d == StReq);
    rd_valid_d = (state_d == StDone) && !io_we_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_req_q      <= 1'b0;
      io_we_q       <= 1'b0;
      io_addr_q     <= '0;
      io_wdata_q    <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      io_req_q      <= io_req_d;
      io_we_q       <= io_we_d;
      io_addr_q     <= io_addr_d;
      io_wdata_q    <= io_wdata_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign io_req      = io_req_q;
  assign io_we       = io_we_q;
  assign io_addr_o   = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
